// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encoding and default widths for the fetch sequencer
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, RECOVER = 2'd2, HALTED = 2'd3} fetch_state_e;
  localparam int FETCH_XLEN = 32;
endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: saturating event counter, cleared by rst
//   clk, rst   clock and synchronous active-high reset
//   inc_i      count one event this cycle
//   cnt_o      current count, sticks at all-ones
module fetch_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer driving pc_gen from flush/halt/predictor/backpressure events
//   inputs : icache_ready, decode_stall, bp_valid/bp_taken/bp_target, rob_flush/rob_flush_pc, halt_req
//   outputs: pc_stall, pc_branch_taken/pc_branch_target, pc_flush/pc_correct_pc, pc_stop_fetch,
//            fetch_valid, state_o
//   FETCH_PERF_CNT_EN adds perf_stall_cyc, perf_flush_cnt, perf_redirect_cnt (CNT_W each)
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int XLEN           = FETCH_XLEN,
  parameter int RECOVER_CYCLES = 2
`ifdef FETCH_PERF_CNT_EN
  ,parameter int CNT_W         = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            icache_ready,
  input  logic            decode_stall,
  input  logic            bp_valid,
  input  logic            bp_taken,
  input  logic [XLEN-1:0] bp_target,
  input  logic            rob_flush,
  input  logic [XLEN-1:0] rob_flush_pc,
  input  logic            halt_req,
  output logic            pc_stall,
  output logic            pc_branch_taken,
  output logic [XLEN-1:0] pc_branch_target,
  output logic            pc_flush,
  output logic [XLEN-1:0] pc_correct_pc,
  output logic            pc_stop_fetch,
  output logic            fetch_valid,
  output logic [1:0]      state_o
`ifdef FETCH_PERF_CNT_EN
  ,output logic [CNT_W-1:0] perf_stall_cyc
  ,output logic [CNT_W-1:0] perf_flush_cnt
  ,output logic [CNT_W-1:0] perf_redirect_cnt
`endif
);
  localparam int CW = RECOVER_CYCLES > 0 ? $clog2(RECOVER_CYCLES + 1) : 1;
  fetch_state_e state_q, state_d;
  logic pend_v_q, pend_v_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stall_cond, bp_hit;
  assign stall_cond = decode_stall | ~icache_ready;
  assign bp_hit = bp_valid & bp_taken;
  assign state_o = rst ? RUN : state_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pend_v_q <= 1'b0;
      pend_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end
  // Priority: HALTED state, halt_req, rob_flush, recovery bubble, then RUN/STALL handling.
  always_comb begin
    state_d          = state_q;
    pend_v_d         = pend_v_q;
    pend_d           = pend_q;
    cnt_d            = cnt_q;
    pc_stall         = 1'b0;
    pc_branch_taken  = 1'b0;
    pc_branch_target = '0;
    pc_flush         = 1'b0;
    pc_correct_pc    = '0;
    pc_stop_fetch    = 1'b0;
    fetch_valid      = 1'b0;
    if (!rst) begin
      if (state_q == HALTED) begin
        pc_stop_fetch = 1'b1;
        pc_stall      = 1'b1;
      end else if (halt_req) begin
        pc_stop_fetch = 1'b1;
        state_d       = HALTED;
      end else if (rob_flush) begin
        pc_flush      = 1'b1;
        pc_correct_pc = rob_flush_pc;
        pend_v_d      = 1'b0;
        cnt_d         = CW'(RECOVER_CYCLES);
        state_d       = RECOVER_CYCLES == 0 ? RUN : RECOVER;
      end else if (state_q == RECOVER) begin
        pc_stall = 1'b1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = stall_cond ? STALL : RUN;
      end else if (stall_cond) begin
        pc_stall = 1'b1;
        state_d  = STALL;
        // Hold the first taken prediction seen while stalled; later ones are dropped.
        if (bp_hit && !pend_v_q) begin
          pend_v_d = 1'b1;
          pend_d   = bp_target;
        end
      end else begin
        fetch_valid      = 1'b1;
        state_d          = RUN;
        pc_branch_taken  = pend_v_q | bp_hit;
        pc_branch_target = pend_v_q ? pend_q : (bp_hit ? bp_target : '0);
        pend_v_d         = 1'b0;
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic run_stall;
  assign run_stall = pc_stall & (state_q == RUN || state_q == STALL);
  fetch_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc_i(run_stall), .cnt_o(perf_stall_cyc));
  fetch_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc_i(pc_flush), .cnt_o(perf_flush_cnt));
  fetch_perf_cnt #(.CNT_W(CNT_W)) u_redir_cnt (.clk(clk), .rst(rst), .inc_i(pc_branch_taken), .cnt_o(perf_redirect_cnt));
`endif
endmodule
